// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, LAUNCH=1, WAIT_DONE=2, ACK=3)
//   DefDataW    : default byte width per requester
//   WdogW       : width of the optional transmit watchdog counter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2,
    StAck      = 2'd3
  } arb_state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned WdogW    = 17;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Searches i_req starting at index i_ptr and wrapping modulo NUM_REQ; reports the first
// set bit. Reusable for any request/grant scheduler (TX arbiter, future RX dispatcher).
// Ports:
//   i_req    [NUM_REQ] : request vector
//   i_ptr    [PTR_W]   : highest-priority index for this search
//   o_winner [PTR_W]   : index of the selected requester (0 when none)
//   o_valid            : at least one request is set
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_winner,
  output logic               o_valid
);

  always_comb begin
    int idx;
    idx      = 0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int off = 0; off < int'(NUM_REQ); off++) begin
      idx = (int'(i_ptr) + off) % int'(NUM_REQ);
      if (!o_valid && i_req[PTR_W'(idx)]) begin
        o_valid  = 1'b1;
        o_winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several byte producers.
// The grant is held for a whole frame, from the start pulse until the UART reports done.
// Optional feature macro: TX_TIMEOUT_EN adds a watchdog that aborts a frame (ack + err)
// after TIMEOUT_CYCLES without i_tx_done. Without it o_err is constant 0.
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_req      [NUM_REQ]     : per-requester level request, held with data until ack
//   i_req_data [NUM_REQ*W]   : requester i byte at [i*DATA_W +: DATA_W]
//   o_gnt      [NUM_REQ]     : one-hot grant, LAUNCH through WAIT_DONE
//   o_ack      [NUM_REQ]     : one-cycle pulse to the winner when its byte finished
//   o_err                    : one-cycle pulse with ack on watchdog abort
//   o_tx_en, o_tx_data       : start pulse and byte to the UART
//   i_tx_done                : UART frame-complete pulse
//   o_busy                   : high whenever not idle
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic                      o_err,
  output logic                      o_tx_en,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          r_state, w_state_d;
  logic [PtrW-1:0]     r_winner, w_winner_d;
  logic [PtrW-1:0]     r_rr_ptr, w_rr_ptr_d;
  logic [PtrW-1:0]     w_pick;
  logic                w_pick_valid;
  logic [DATA_W-1:0]   r_tx_data, w_tx_data_d;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_d;
  logic [NUM_REQ-1:0]  r_ack, w_ack_d;
  logic                r_tx_en, w_tx_en_d;
  logic                r_busy, w_busy_d;
  logic                r_err, w_err_d;
  logic                w_wd_expire;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

`ifdef TX_TIMEOUT_EN
  logic [WdogW-1:0] r_wd;

  always_ff @(posedge i_clk) begin
    if (i_reset || r_state == StLaunch) begin
      r_wd <= '0;
    end else if (r_state == StWaitDone) begin
      r_wd <= r_wd + WdogW'(1);
    end
  end

  // r_wd is 0 in the first WAIT_DONE cycle; firing at TIMEOUT_CYCLES-2 puts the ACK
  // cycle exactly TIMEOUT_CYCLES after LAUNCH.
  assign w_wd_expire = (r_state == StWaitDone) && (r_wd == WdogW'(TIMEOUT_CYCLES - 2));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_wd_expire      = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_winner_d  = r_winner;
    w_rr_ptr_d  = r_rr_ptr;
    w_tx_data_d = r_tx_data;
    w_err_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state_d   = StLaunch;
          w_winner_d  = w_pick;
          w_tx_data_d = i_req_data[w_pick*DATA_W +: DATA_W];
        end
      end
      StLaunch: w_state_d = StWaitDone;
      StWaitDone: begin
        if (i_tx_done) begin
          w_state_d = StAck;
        end else if (w_wd_expire) begin
          w_state_d = StAck;
          w_err_d   = 1'b1;
        end
      end
      StAck: begin
        w_state_d  = StIdle;
        w_rr_ptr_d = (r_winner == PtrW'(NUM_REQ - 1)) ? '0 : r_winner + PtrW'(1);
      end
      default: w_state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    w_tx_en_d = (w_state_d == StLaunch);
    w_busy_d  = (w_state_d != StIdle);
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_gnt_d[i] = ((w_state_d == StLaunch) || (w_state_d == StWaitDone)) &&
                   (w_winner_d == PtrW'(i));
      w_ack_d[i] = (w_state_d == StAck) && (w_winner_d == PtrW'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_winner  <= '0;
      r_rr_ptr  <= '0;
      r_tx_data <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_tx_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_winner  <= w_winner_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_tx_data <= w_tx_data_d;
      r_gnt     <= w_gnt_d;
      r_ack     <= w_ack_d;
      r_tx_en   <= w_tx_en_d;
      r_busy    <= w_busy_d;
      r_err     <= w_err_d;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_tx_en   = r_tx_en;
  assign o_tx_data = r_tx_data;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=2, DATA_W=8, TIMEOUT_CYCLES=20).
// Expected launches are queued when requests are driven and popped when tx_en appears.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic        err;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned id;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req      (req),
    .i_req_data (req_data),
    .o_gnt      (gnt),
    .o_ack      (ack),
    .o_err      (err),
    .o_tx_en    (tx_en),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  function automatic logic [1:0] oh(input int unsigned i);
    oh = 2'b01 << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits at most 'budget' cycles for tx_en, then checks grant and byte against the queue.
  task automatic wait_launch(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (!tx_en && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_en"}, {31'd0, tx_en}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=launch expected=no_launch", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gnt"}, {30'd0, gnt}, {30'd0, oh(e.id)});
      chk({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, e.data});
    end
  endtask

  // Called in the LAUNCH cycle; returns in the IDLE cycle after ACK.
  task automatic do_frame(input string tag, input int frame_cycles, input int unsigned id);
    repeat (frame_cycles) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, "_ack"}, {30'd0, ack}, {30'd0, oh(id)});
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_gnt_at_ack"}, {30'd0, gnt}, 32'd0);
    @(negedge clk);
    chk({tag, "_ack_clear"}, {30'd0, ack}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    req      = 2'b00;
    req_data = 16'h0000;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request; data changed after latch must not leak through.
    req = 2'b01; req_data = 16'h00A5; push(0, 8'hA5);
    wait_launch("single", 1);
    req_data = 16'h005A;
    @(negedge clk);
    chk("single_tx_en_pulse", {31'd0, tx_en}, 32'd0);
    chk("single_gnt_hold", {30'd0, gnt}, 32'd1);
    chk("single_data_hold", {24'd0, tx_data}, 32'hA5);
    do_frame("single", 3, 0);
    req = 2'b00;
    @(negedge clk);

    // Contention from rr_ptr=0: requester 0 then 1, both holding req.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11; req_data = 16'h2211; push(0, 8'h11); push(1, 8'h22);
    wait_launch("cont0", 1);
    do_frame("cont0", 3, 0);
    wait_launch("cont1", 1);
    do_frame("cont1", 2, 1);
    req = 2'b00;
    @(negedge clk);

    // Fairness: req[0] continuous, req[1] pulsed; grants 0,1,0.
    req = 2'b01; req_data = 16'h4433; push(0, 8'h33);
    wait_launch("fair0", 1);
    req = 2'b11; push(1, 8'h44);
    do_frame("fair0", 2, 0);
    wait_launch("fair1", 1);
    req = 2'b01;                       // dropped mid-frame: ack must still come
    push(0, 8'h33);
    do_frame("fair1", 3, 1);
    wait_launch("fair2", 1);
    do_frame("fair2", 2, 0);
    req = 2'b00;
    @(negedge clk);

    // Stray tx_done in IDLE and in LAUNCH.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stray_idle_ack", {30'd0, ack}, 32'd0);
    chk("stray_idle_busy", {31'd0, busy}, 32'd0);
    req = 2'b10; req_data = 16'h5500; push(1, 8'h55);
    wait_launch("stray", 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stray_launch_ack", {30'd0, ack}, 32'd0);
    chk("stray_launch_busy", {31'd0, busy}, 32'd1);
    chk("stray_launch_gnt", {30'd0, gnt}, 32'd2);
    do_frame("stray", 2, 1);
    req = 2'b00;
    @(negedge clk);

    // Reset mid-frame abandons the frame without ack.
    req = 2'b01; req_data = 16'h0066; push(0, 8'h66);
    wait_launch("rstmid", 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_gnt", {30'd0, gnt}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_ack", {30'd0, ack}, 32'd0);
    @(negedge clk);
    chk("rstmid_no_late_ack", {30'd0, ack}, 32'd0);
    req = 2'b01; req_data = 16'h0077; push(0, 8'h77);
    wait_launch("rstmid_fresh", 1);
    do_frame("rstmid_fresh", 2, 0);
    req = 2'b00;
    @(negedge clk);

    // No tx_done ever: watchdog abort, or indefinite wait without the feature.
    req = 2'b01; req_data = 16'h0088; push(0, 8'h88);
    wait_launch("wd", 1);
    req = 2'b00;
    cnt = 0;
`ifdef TX_TIMEOUT_EN
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (ack != 2'b00 || err) cnt++;
    end
    chk("wd_early_ack", cnt, 0);
    @(negedge clk);
    chk("wd_ack", {30'd0, ack}, 32'd1);
    chk("wd_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    chk("wd_ack_clear", {30'd0, ack}, 32'd0);
    chk("wd_err_clear", {31'd0, err}, 32'd0);
    chk("wd_idle", {31'd0, busy}, 32'd0);
`else
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (ack != 2'b00 || err || !busy) cnt++;
    end
    chk("nowd_events", cnt, 0);
    chk("nowd_busy", {31'd0, busy}, 32'd1);
    chk("nowd_gnt", {30'd0, gnt}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("nowd_rst_busy", {31'd0, busy}, 32'd0);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
